// File: rtl/pad_cfg_sequencer.sv
// Pad reconfiguration sequencer: drops OE, settles, writes attributes,
// settles, then restores OE so attributes never change on a driving pad.
module pad_cfg_sequencer #(
    parameter int                 NUM_PADS      = 8,
    parameter int                 PADATTR       = 16,
    parameter int                 SETTLE_CYCLES = 4,
    parameter logic [PADATTR-1:0] RESET_ATTR    = '0,
    parameter int                 IDX_W         = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [IDX_W-1:0]              req_idx_i,
    input  logic                          req_oe_i,
    input  logic [PADATTR-1:0]            req_attr_i,
    output logic                          done_o,
    output logic                          err_o,
    output logic                          busy_o,
    output logic [NUM_PADS-1:0]           pad_oe_o,
    output logic [NUM_PADS*PADATTR-1:0]   pad_attr_o
);

    localparam int                CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W:0]    NP       = (IDX_W + 1)'(NUM_PADS);

    typedef enum logic [1:0] {
        IDLE,
        OE_OFF_WAIT,
        ATTR_WAIT,
        FINISH
    } state_e;

    state_e                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          oe_lat_q, oe_lat_d;
    logic [PADATTR-1:0]            attr_lat_q, attr_lat_d;
    logic [NUM_PADS-1:0]           oe_q, oe_d;
    logic [NUM_PADS*PADATTR-1:0]   attr_q, attr_d;
    logic                          ready_q, ready_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          err_q, err_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        oe_lat_d   = oe_lat_q;
        attr_lat_d = attr_lat_q;
        oe_d       = oe_q;
        attr_d     = attr_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i && ready_q) begin
                    idx_d      = req_idx_i;
                    oe_lat_d   = req_oe_i;
                    attr_lat_d = req_attr_i;
                    if ({1'b0, req_idx_i} < NP) begin
                        for (int k = 0; k < NUM_PADS; k++) begin
                            if (req_idx_i == IDX_W'(k)) oe_d[k] = 1'b0;
                        end
                        cnt_d   = CNT_LOAD;
                        state_d = OE_OFF_WAIT;
                    end else begin
                        // Out-of-range index: complete at once, pads untouched
                        state_d = FINISH;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            OE_OFF_WAIT: begin
                if (cnt_q == '0) begin
                    for (int k = 0; k < NUM_PADS; k++) begin
                        if (idx_q == IDX_W'(k)) attr_d[k*PADATTR +: PADATTR] = attr_lat_q;
                    end
                    cnt_d   = CNT_LOAD;
                    state_d = ATTR_WAIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ATTR_WAIT: begin
                if (cnt_q == '0) begin
                    for (int k = 0; k < NUM_PADS; k++) begin
                        if (idx_q == IDX_W'(k)) oe_d[k] = oe_lat_q;
                    end
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            oe_lat_q   <= 1'b0;
            attr_lat_q <= '0;
            oe_q       <= '0;
            attr_q     <= {NUM_PADS{RESET_ATTR}};
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            oe_lat_q   <= oe_lat_d;
            attr_lat_q <= attr_lat_d;
            oe_q       <= oe_d;
            attr_q     <= attr_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign req_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign pad_oe_o    = oe_q;
    assign pad_attr_o  = attr_q;

endmodule
